// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (ibus, dbus), one-slave memory arbiter.
// A registered grant FSM serialises accesses to the single memory port.
// dbus has priority, and a starvation counter forces an ibus grant after
// STARVE_MAX consecutive dbus grants taken while ibus was waiting.
// A watchdog ends a BUSY phase with an error completion after TIMEOUT
// cycles without mem_ready.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MASK_W     = 4,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_bus_req,
   input  logic              i_bus_we,
   input  logic [ADDR_W-1:0] i_bus_addr,
   input  logic [DATA_W-1:0] i_bus_wdata,
   input  logic [MASK_W-1:0] i_bus_mask,
   output logic [DATA_W-1:0] i_bus_rdata,
   output logic              i_bus_ready,
   output logic              i_bus_err,

   input  logic              d_bus_req,
   input  logic              d_bus_we,
   input  logic [ADDR_W-1:0] d_bus_addr,
   input  logic [DATA_W-1:0] d_bus_wdata,
   input  logic [MASK_W-1:0] d_bus_mask,
   output logic [DATA_W-1:0] d_bus_rdata,
   output logic              d_bus_ready,
   output logic              d_bus_err,

   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_mask,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   // Starvation limit and last watchdog count, in the counters' own widths.
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [3:0]        starve_cnt;
   logic [7:0]        wd_cnt;

   // Payload of the granted master, captured once at grant.
   logic              pl_we;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_wdata;
   logic [MASK_W-1:0] pl_mask;

   logic              grant_i;
   logic              grant_d;
   logic              busy;
   logic              busy_i;
   logic              busy_d;
   logic              wd_expired;
   logic              done;

   assign busy_i = (state == BUSY_I);
   assign busy_d = (state == BUSY_D);
   assign busy   = busy_i || busy_d;

   // A watchdog error only fires when the slave has not answered this cycle;
   // a late mem_ready in the final cycle still wins as a normal completion.
   assign wd_expired = busy && !mem_ready && (wd_cnt == WD_LAST);
   assign done       = busy && (mem_ready || wd_expired);

   // Arbitration in IDLE: dbus first unless ibus has been starved too long.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the if/else leaves it unassigned and infers a latch.
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         if (i_bus_req && ((starve_cnt == STARVE_LIM) || !d_bus_req)) begin
            grant_i = 1'b1;
         end else if (d_bus_req) begin
            grant_d = 1'b1;
         end
      end
   end

   // Next-state logic: every completion returns to IDLE for re-arbitration.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_i) begin
               state_nxt = BUSY_I;
            end else if (grant_d) begin
               state_nxt = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any in-flight transaction immediately.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block evaluation order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Starvation counter: counts dbus grants that bypassed a waiting ibus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d) begin
         if (!i_bus_req) begin
            starve_cnt <= '0;
         end else if (starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end
   end

   // Watchdog: counts BUSY cycles without mem_ready, restarted on each grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (grant_i || grant_d) begin
         wd_cnt <= '0;
      end else if (busy && !mem_ready && !wd_expired) begin
         wd_cnt <= wd_cnt + 8'd1;
      end
   end

   // Payload capture at grant; inputs are ignored for the rest of BUSY.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the payload is reset even though mem_* are gated outside BUSY,
      // so nothing downstream can ever observe an uninitialised value.
      if (rst) begin
         pl_we    <= 1'b0;
         pl_addr  <= '0;
         pl_wdata <= '0;
         pl_mask  <= '0;
      end else if (grant_i) begin
         pl_we    <= i_bus_we;
         pl_addr  <= i_bus_addr;
         pl_wdata <= i_bus_wdata;
         pl_mask  <= i_bus_mask;
      end else if (grant_d) begin
         pl_we    <= d_bus_we;
         pl_addr  <= d_bus_addr;
         pl_wdata <= d_bus_wdata;
         pl_mask  <= d_bus_mask;
      end
   end

   // Output steering: memory port and completions are live only in BUSY.
   always_comb begin
      mem_req     = busy;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_mask    = '0;
      i_bus_ready = 1'b0;
      i_bus_err   = 1'b0;
      i_bus_rdata = '0;
      d_bus_ready = 1'b0;
      d_bus_err   = 1'b0;
      d_bus_rdata = '0;

      if (busy) begin
         mem_we    = pl_we;
         mem_addr  = pl_addr;
         mem_wdata = pl_wdata;
         mem_mask  = pl_mask;
      end

      if (busy_i) begin
         i_bus_ready = mem_ready || wd_expired;
         i_bus_err   = wd_expired;
         if (mem_ready) begin
            i_bus_rdata = mem_rdata;
         end
      end

      if (busy_d) begin
         d_bus_ready = mem_ready || wd_expired;
         d_bus_err   = wd_expired;
         if (mem_ready) begin
            d_bus_rdata = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a table of per-cycle input/expected-output
// records, plus hand-written sequences for contention, timeout and reset.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MASK_W     = 4;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 8;

   localparam logic [31:0] A0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h8000_0100;
   localparam logic [31:0] AD = 32'h0000_0200;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_bus_req, i_bus_we, i_bus_ready, i_bus_err;
   logic [ADDR_W-1:0] i_bus_addr;
   logic [DATA_W-1:0] i_bus_wdata, i_bus_rdata;
   logic [MASK_W-1:0] i_bus_mask;
   logic              d_bus_req, d_bus_we, d_bus_ready, d_bus_err;
   logic [ADDR_W-1:0] d_bus_addr;
   logic [DATA_W-1:0] d_bus_wdata, d_bus_rdata;
   logic [MASK_W-1:0] d_bus_mask;
   logic              mem_req, mem_we, mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [MASK_W-1:0] mem_mask;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
      .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .i_bus_req(i_bus_req), .i_bus_we(i_bus_we), .i_bus_addr(i_bus_addr),
      .i_bus_wdata(i_bus_wdata), .i_bus_mask(i_bus_mask), .i_bus_rdata(i_bus_rdata),
      .i_bus_ready(i_bus_ready), .i_bus_err(i_bus_err),
      .d_bus_req(d_bus_req), .d_bus_we(d_bus_we), .d_bus_addr(d_bus_addr),
      .d_bus_wdata(d_bus_wdata), .d_bus_mask(d_bus_mask), .d_bus_rdata(d_bus_rdata),
      .d_bus_ready(d_bus_ready), .d_bus_err(d_bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct {
      logic        i_req;
      logic        i_we;
      logic [31:0] i_addr;
      logic [31:0] i_wdata;
      logic [3:0]  i_mask;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_mask;
      logic        m_ready;
      logic [31:0] m_rdata;
   } in_t;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic        i_ready;
      logic        i_err;
      logic [31:0] i_rdata;
      logic        d_ready;
      logic        d_err;
      logic [31:0] d_rdata;
   } exp_t;

   typedef struct {
      in_t  in;
      exp_t exp;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic drive(input in_t v);
      i_bus_req   = v.i_req;
      i_bus_we    = v.i_we;
      i_bus_addr  = v.i_addr;
      i_bus_wdata = v.i_wdata;
      i_bus_mask  = v.i_mask;
      d_bus_req   = v.d_req;
      d_bus_we    = v.d_we;
      d_bus_addr  = v.d_addr;
      d_bus_wdata = v.d_wdata;
      d_bus_mask  = v.d_mask;
      mem_ready   = v.m_ready;
      mem_rdata   = v.m_rdata;
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, "_mem_req"},   64'(mem_req),     64'(e.req));
      check({tag, "_mem_we"},    64'(mem_we),      64'(e.we));
      check({tag, "_mem_addr"},  64'(mem_addr),    64'(e.addr));
      check({tag, "_mem_wdata"}, 64'(mem_wdata),   64'(e.wdata));
      check({tag, "_mem_mask"},  64'(mem_mask),    64'(e.mask));
      check({tag, "_i_ready"},   64'(i_bus_ready), 64'(e.i_ready));
      check({tag, "_i_err"},     64'(i_bus_err),   64'(e.i_err));
      check({tag, "_i_rdata"},   64'(i_bus_rdata), 64'(e.i_rdata));
      check({tag, "_d_ready"},   64'(d_bus_ready), 64'(e.d_ready));
      check({tag, "_d_err"},     64'(d_bus_err),   64'(e.d_err));
      check({tag, "_d_rdata"},   64'(d_bus_rdata), 64'(e.d_rdata));
   endtask

   // Hold reset for two cycles with quiet inputs; returns at a falling edge.
   task automatic do_reset();
      in_t z;
      z = '{default: '0};
      rst = 1'b1;
      drive(z);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Records up to n completions: bit k of g is 1 when completion k went to ibus.
   // Called at a falling edge; returns at the falling edge after the last one.
   task automatic collect(input int n, output logic [15:0] g, output int got);
      g   = '0;
      got = 0;
      for (int c = 0; c < 4 * n && got < n; c++) begin
         #1;
         if (d_bus_ready) begin
            got++;
         end else if (i_bus_ready) begin
            g[got] = 1'b1;
            got++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not terminate in time");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[19];
      in_t         z, dn, iw, both, busy_in;
      exp_t        ez, e_wr;
      logic [15:0] g;
      int          got;
      int          busy_cycles;
      logic        seen, err_s;
      logic [31:0] rd_s;

      z  = '{default: '0};
      ez = '{default: '0};

      // Reset state: requests and mem_ready are up, yet nothing may move.
      both = '{1'b1, 1'b0, A0, '0, '0, 1'b1, 1'b0, AD, '0, 4'hF, 1'b1, 32'h31};
      rst = 1'b1;
      drive(both);
      repeat (2) @(negedge clk);
      #1;
      check_outputs("reset", ez);

      // ---------------- cycle table ----------------
      dn   = '{1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h1234, '0, 4'hF, 1'b0, 32'h77};
      iw   = '{1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hC, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0};
      both = '{1'b1, 1'b0, A0, '0, '0, 1'b1, 1'b0, AD, '0, 4'hF, 1'b0, '0};
      e_wr = '{1'b1, 1'b1, A1, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0};

      // idle noise
      vecs[0] = '{'{1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h55}, ez};
      vecs[1] = '{z, ez};
      // single ibus read answered in the first BUSY cycle
      vecs[2] = '{'{1'b1, 1'b0, A0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0}, ez};
      vecs[3] = '{'{1'b1, 1'b0, A0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h413},
                  '{1'b1, 1'b0, A0, '0, 4'h0, 1'b1, 1'b0, 32'h413, 1'b0, 1'b0, '0}};
      vecs[4] = '{z, ez};
      // dbus write, slave answers in the 4th BUSY cycle, inputs change mid-BUSY
      vecs[5] = '{'{1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, A1, 32'hDEAD_BEEF, 4'h3, 1'b0, '0}, ez};
      vecs[6] = '{dn, e_wr};
      vecs[7] = '{dn, e_wr};
      vecs[8] = '{dn, e_wr};
      busy_in = dn;
      busy_in.m_ready = 1'b1;
      busy_in.m_rdata = 32'hAA;
      vecs[9] = '{busy_in, '{1'b1, 1'b1, A1, 32'hDEAD_BEEF, 4'h3, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hAA}};
      vecs[10] = '{z, ez};
      // ibus write, request held after ready -> re-arbitrated, mem_ready in IDLE ignored
      vecs[11] = '{iw, ez};
      busy_in = iw;
      busy_in.m_ready = 1'b1;
      busy_in.m_rdata = 32'h99;
      vecs[12] = '{busy_in, '{1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hC, 1'b1, 1'b0, 32'h99, 1'b0, 1'b0, '0}};
      vecs[13] = '{busy_in, ez};
      busy_in.m_rdata = 32'h5;
      vecs[14] = '{busy_in, '{1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hC, 1'b1, 1'b0, 32'h5, 1'b0, 1'b0, '0}};
      vecs[15] = '{z, ez};
      // simultaneous requests with starve_cnt = 0: dbus wins
      vecs[16] = '{both, ez};
      busy_in = both;
      busy_in.m_ready = 1'b1;
      busy_in.m_rdata = 32'h22;
      vecs[17] = '{busy_in, '{1'b1, 1'b0, AD, '0, 4'hF, 1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h22}};
      vecs[18] = '{z, ez};

      do_reset();
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         drive(vecs[k].in);
         #1;
         check_outputs($sformatf("row%0d", k), vecs[k].exp);
      end

      // ---------------- contention and starvation guard ----------------
      do_reset();
      both.m_ready = 1'b1;
      both.m_rdata = 32'h31;
      drive(both);
      collect(10, g, got);
      check("contention_count", 64'(got), 64'd10);
      check("contention_order", 64'(g), 64'h0210);
      drive(z);

      // ---------------- asynchronous reset mid BUSY_D ----------------
      do_reset();
      drive(both);
      collect(3, g, got);
      check("prerst_count", 64'(got), 64'd3);
      check("prerst_order", 64'(g), 64'h0);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("rst_busy1_mem_req", 64'(mem_req), 64'd1);
      check("rst_busy1_mem_addr", 64'(mem_addr), 64'(AD));
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = 32'h5A;
      #1;
      check("rst_busy2_d_ready", 64'(d_bus_ready), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_d_ready", 64'(d_bus_ready), 64'd0);
      check("rst_d_rdata", 64'(d_bus_rdata), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      collect(5, g, got);
      check("postrst_count", 64'(got), 64'd5);
      check("postrst_order", 64'(g), 64'h0010);
      drive(z);

      // ---------------- watchdog timeout ----------------
      do_reset();
      i_bus_req  = 1'b1;
      i_bus_addr = 32'h100;
      mem_rdata  = 32'hFFFF_FFFF;
      mem_ready  = 1'b0;
      busy_cycles = 0;
      seen  = 1'b0;
      err_s = 1'b0;
      rd_s  = '0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         #1;
         if (mem_req) busy_cycles++;
         if (i_bus_ready) begin
            seen  = 1'b1;
            err_s = i_bus_err;
            rd_s  = i_bus_rdata;
         end
      end
      check("to_ready_seen", 64'(seen), 64'd1);
      check("to_busy_cycles", 64'(busy_cycles), 64'(TIMEOUT));
      check("to_err", 64'(err_s), 64'd1);
      check("to_rdata", 64'(rd_s), 64'd0);
      i_bus_req = 1'b0;
      @(negedge clk);
      #1;
      check("to_idle_mem_req", 64'(mem_req), 64'd0);
      check("to_idle_i_ready", 64'(i_bus_ready), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
